// File: rtl/vx_sched_wctl_driver.sv
// Warp-control command driver: queues TMC / WSPAWN / JOIN commands and issues them as one-cycle events.
// Define VX_SCHED_DRV_TIMEOUT_EN to enable the WAIT watchdog (sticky timeout_err, command dropped).
//
// state | meaning
// IDLE  | waiting for a queued command to pop
// GAP   | counting down the command's idle-cycle delay
// WAIT  | target warp(s) stalled, command held
// ISSUE | event pulse and payload presented this cycle
module vx_sched_wctl_driver #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int PC_BITS     = 30,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [$clog2(NUM_WARPS)-1:0] cmd_wid,
    input  logic [NUM_THREADS-1:0]       cmd_tmask,
    input  logic [NUM_WARPS-1:0]         cmd_wmask,
    input  logic [PC_BITS-1:0]           cmd_pc,
    input  logic [3:0]                   cmd_delay,
    input  logic [NUM_WARPS-1:0]         stalled_warps,
    output logic                         warp_ctl_valid,
    output logic                         wspawn_valid,
    output logic                         join_valid,
    output logic [$clog2(NUM_WARPS)-1:0] wid,
    output logic [NUM_THREADS-1:0]       thread_mask,
    output logic [NUM_WARPS-1:0]         warp_mask,
    output logic [PC_BITS-1:0]           result_pc,
    output logic [15:0]                  issued_count,
    output logic                         timeout_err,
    output logic                         busy
);

    localparam int WID_W = $clog2(NUM_WARPS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

    localparam logic [1:0] OP_TMC    = 2'd0;
    localparam logic [1:0] OP_WSPAWN = 2'd1;
    localparam logic [1:0] OP_JOIN   = 2'd2;
    localparam logic [1:0] OP_RSVD   = 2'd3;

    typedef struct packed {
        logic [1:0]             op;
        logic [WID_W-1:0]       wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [NUM_WARPS-1:0]   wmask;
        logic [PC_BITS-1:0]     pc;
        logic [3:0]             delay;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_WAIT, S_ISSUE} state_t;

    cmd_t                   fifo_mem [FIFO_DEPTH];
    cmd_t                   cmd_in;
    cmd_t                   head;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]         count_q, count_d;
    logic                   push, pop, empty, full;

    state_t                 state_q, state_d;
    logic [1:0]             cur_op_q, cur_op_d;
    logic [WID_W-1:0]       cur_wid_q, cur_wid_d;
    logic [NUM_THREADS-1:0] cur_tmask_q, cur_tmask_d;
    logic [NUM_WARPS-1:0]   cur_wmask_q, cur_wmask_d;
    logic [PC_BITS-1:0]     cur_pc_q, cur_pc_d;
    logic [3:0]             gap_q, gap_d;
    logic                   target_free, issue_now;

    logic                   ctl_q, ctl_d, wsp_q, wsp_d, jn_q, jn_d;
    logic [WID_W-1:0]       wid_q, wid_d;
    logic [NUM_THREADS-1:0] tmask_q, tmask_d;
    logic [NUM_WARPS-1:0]   wmask_q, wmask_d;
    logic [PC_BITS-1:0]     pc_q, pc_d;
    logic [15:0]            issued_q, issued_d;

`ifdef VX_SCHED_DRV_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT - 1);
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic                   err_q, err_d;
`endif

    assign cmd_in = '{op: cmd_op, wid: cmd_wid, tmask: cmd_tmask, wmask: cmd_wmask,
                      pc: cmd_pc, delay: cmd_delay};
    assign head   = fifo_mem[rd_ptr_q];
    assign empty  = (count_q == '0);
    assign full   = (count_q == DEPTH_CNT);
    assign push   = cmd_valid && !full;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= cmd_in;
        end
    end

    // WSPAWN needs every targeted warp free; TMC/JOIN only the addressed warp
    assign target_free = (cur_op_q == OP_WSPAWN) ? ((stalled_warps & cur_wmask_q) == '0)
                                                 : !stalled_warps[cur_wid_q];

    always_comb begin
        state_d     = state_q;
        cur_op_d    = cur_op_q;
        cur_wid_d   = cur_wid_q;
        cur_tmask_d = cur_tmask_q;
        cur_wmask_d = cur_wmask_q;
        cur_pc_d    = cur_pc_q;
        gap_d       = gap_q;
        pop         = 1'b0;
        issue_now   = 1'b0;
`ifdef VX_SCHED_DRV_TIMEOUT_EN
        wait_d      = wait_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    cur_op_d    = head.op;
                    cur_wid_d   = head.wid;
                    cur_tmask_d = head.tmask;
                    cur_wmask_d = head.wmask;
                    cur_pc_d    = head.pc;
                    if (head.op != OP_RSVD) begin
                        gap_d   = head.delay;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_q != 4'd0) begin
                    gap_d = gap_q - 4'd1;
                end else if (target_free) begin
                    issue_now = 1'b1;
                end else begin
                    state_d = S_WAIT;
`ifdef VX_SCHED_DRV_TIMEOUT_EN
                    wait_d  = WAIT_LOAD;
`endif
                end
            end
            S_WAIT: begin
                if (target_free) begin
                    issue_now = 1'b1;
                end
`ifdef VX_SCHED_DRV_TIMEOUT_EN
                else if (wait_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
`endif
            end
            S_ISSUE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (issue_now) begin
            state_d = S_ISSUE;
        end

        ctl_d    = issue_now && (cur_op_q == OP_TMC);
        wsp_d    = issue_now && (cur_op_q == OP_WSPAWN);
        jn_d     = issue_now && (cur_op_q == OP_JOIN);
        wid_d    = wid_q;
        tmask_d  = tmask_q;
        wmask_d  = wmask_q;
        pc_d     = pc_q;
        issued_d = issued_q;
        if (issue_now) begin
            wid_d   = cur_wid_q;
            tmask_d = cur_tmask_q;
            wmask_d = (cur_op_q == OP_WSPAWN) ? cur_wmask_q : '0;
            pc_d    = cur_pc_q;
            if (issued_q != 16'hFFFF) begin
                issued_d = issued_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            cur_op_q    <= '0;
            cur_wid_q   <= '0;
            cur_tmask_q <= '0;
            cur_wmask_q <= '0;
            cur_pc_q    <= '0;
            gap_q       <= '0;
            ctl_q       <= 1'b0;
            wsp_q       <= 1'b0;
            jn_q        <= 1'b0;
            wid_q       <= '0;
            tmask_q     <= '0;
            wmask_q     <= '0;
            pc_q        <= '0;
            issued_q    <= '0;
`ifdef VX_SCHED_DRV_TIMEOUT_EN
            wait_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            cur_op_q    <= cur_op_d;
            cur_wid_q   <= cur_wid_d;
            cur_tmask_q <= cur_tmask_d;
            cur_wmask_q <= cur_wmask_d;
            cur_pc_q    <= cur_pc_d;
            gap_q       <= gap_d;
            ctl_q       <= ctl_d;
            wsp_q       <= wsp_d;
            jn_q        <= jn_d;
            wid_q       <= wid_d;
            tmask_q     <= tmask_d;
            wmask_q     <= wmask_d;
            pc_q        <= pc_d;
            issued_q    <= issued_d;
`ifdef VX_SCHED_DRV_TIMEOUT_EN
            wait_q      <= wait_d;
            err_q       <= err_d;
`endif
        end
    end

    assign cmd_ready      = !full;
    assign warp_ctl_valid = ctl_q;
    assign wspawn_valid   = wsp_q;
    assign join_valid     = jn_q;
    assign wid            = wid_q;
    assign thread_mask    = tmask_q;
    assign warp_mask      = wmask_q;
    assign result_pc      = pc_q;
    assign issued_count   = issued_q;
    assign busy           = (state_q != S_IDLE) || !empty;
`ifdef VX_SCHED_DRV_TIMEOUT_EN
    assign timeout_err    = err_q;
`else
    assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_vx_sched_wctl_driver.sv
// Bench for vx_sched_wctl_driver: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed event cycles and payloads.
`timescale 1ns/1ps
module tb_vx_sched_wctl_driver;
    localparam int DEPTH = 4;
    localparam int TMO   = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_wid;
    logic [3:0]  cmd_tmask;
    logic [3:0]  cmd_wmask;
    logic [29:0] cmd_pc;
    logic [3:0]  cmd_delay;
    logic [3:0]  stalled_warps;
    logic        warp_ctl_valid, wspawn_valid, join_valid;
    logic [1:0]  wid;
    logic [3:0]  thread_mask;
    logic [3:0]  warp_mask;
    logic [29:0] result_pc;
    logic [15:0] issued_count;
    logic        timeout_err;
    logic        busy;

    vx_sched_wctl_driver #(
        .NUM_WARPS(4), .NUM_THREADS(4), .PC_BITS(30), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wid(cmd_wid),
        .cmd_tmask(cmd_tmask), .cmd_wmask(cmd_wmask), .cmd_pc(cmd_pc), .cmd_delay(cmd_delay),
        .stalled_warps(stalled_warps),
        .warp_ctl_valid(warp_ctl_valid), .wspawn_valid(wspawn_valid), .join_valid(join_valid),
        .wid(wid), .thread_mask(thread_mask), .warp_mask(warp_mask), .result_pc(result_pc),
        .issued_count(issued_count), .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model: commands with issue timestamps ----------------
    typedef struct packed {
        logic [1:0]  op;
        logic [1:0]  wid;
        logic [3:0]  tmask;
        logic [3:0]  wmask;
        logic [29:0] pc;
        logic [3:0]  delay;
    } mcmd_t;

    mcmd_t       m_q[$];
    mcmd_t       m_cur;
    bit          m_inflight;
    int          m_elig, m_avail, m_cnt;
    bit          m_err;
    bit          e_ctl, e_wsp, e_jn;
    logic [1:0]  e_wid;
    logic [3:0]  e_tm, e_wm;
    logic [29:0] e_pc;

    bit          p_rst = 1'b0;
    bit          p_valid;
    mcmd_t       p_cmd;
    logic [3:0]  p_stall;

    function automatic void model_clear();
        m_q.delete();
        m_inflight = 0; m_elig = 0; m_avail = 0; m_cnt = 0; m_err = 0;
        e_ctl = 0; e_wsp = 0; e_jn = 0;
        e_wid = '0; e_tm = '0; e_wm = '0; e_pc = '0;
    endfunction

    // Edge e consumes the inputs held during cycle e-1 (p_*).
    function automatic void model_edge(input int e);
        bit full_before;
        bit free;
        mcmd_t c;
        e_ctl = 0; e_wsp = 0; e_jn = 0;
        full_before = (m_q.size() >= DEPTH);
        if (m_inflight && e >= m_elig) begin
            free = (m_cur.op == 2'd1) ? ((p_stall & m_cur.wmask) == 4'b0)
                                      : (p_stall[m_cur.wid] == 1'b0);
            if (free) begin
                e_ctl = (m_cur.op == 2'd0);
                e_wsp = (m_cur.op == 2'd1);
                e_jn  = (m_cur.op == 2'd2);
                e_wid = m_cur.wid;
                e_tm  = m_cur.tmask;
                e_wm  = (m_cur.op == 2'd1) ? m_cur.wmask : 4'b0;
                e_pc  = m_cur.pc;
                if (m_cnt < 65535) m_cnt++;
                m_inflight = 0;
                m_avail = e + 2;
            end
`ifdef VX_SCHED_DRV_TIMEOUT_EN
            else if (e - m_elig >= TMO) begin
                m_err = 1;
                m_inflight = 0;
                m_avail = e + 1;
            end
`endif
        end
        if (!m_inflight && e >= m_avail && m_q.size() > 0) begin
            c = m_q.pop_front();
            if (c.op == 2'd3) begin
                m_avail = e + 1;
            end else begin
                m_cur = c;
                m_inflight = 1;
                m_elig = e + 1 + int'(c.delay);
            end
        end
        if (p_valid && !full_before) m_q.push_back(p_cmd);
    endfunction

    always @(negedge clk) begin
        if (!reset) model_clear();
        else if (p_rst) model_edge(cyc);
        chk("m_ctl", warp_ctl_valid, e_ctl);
        chk("m_wsp", wspawn_valid, e_wsp);
        chk("m_join", join_valid, e_jn);
        chk("m_wid", wid, e_wid);
        chk("m_tmask", thread_mask, e_tm);
        chk("m_wmask", warp_mask, e_wm);
        chk("m_pc", result_pc, e_pc);
        chk("m_count", issued_count, m_cnt);
        chk("m_terr", timeout_err, m_err);
        chk("m_busy", busy, m_inflight || e_ctl || e_wsp || e_jn || (m_q.size() > 0));
        chk("m_ready", cmd_ready, m_q.size() < DEPTH);
        p_rst   = reset;
        p_valid = cmd_valid;
        p_cmd   = '{op: cmd_op, wid: cmd_wid, tmask: cmd_tmask, wmask: cmd_wmask,
                    pc: cmd_pc, delay: cmd_delay};
        p_stall = stalled_warps;
    end

    // ---------------- event monitor for directed literal checks ----------------
    int          n_ctl = 0, n_wsp = 0, n_jn = 0;
    int          last_ctl = -1, last_wsp = -1, last_jn = -1, first_err = -1;
    logic [1:0]  cap_wid;
    logic [3:0]  cap_tm, cap_wm;
    logic [29:0] cap_pc;
    logic [29:0] log_pc[$];

    always @(negedge clk) begin
        if (warp_ctl_valid) begin n_ctl++; last_ctl = cyc; end
        if (wspawn_valid)   begin n_wsp++; last_wsp = cyc; end
        if (join_valid)     begin n_jn++;  last_jn  = cyc; end
        if (warp_ctl_valid || wspawn_valid || join_valid) begin
            cap_wid = wid; cap_tm = thread_mask; cap_wm = warp_mask; cap_pc = result_pc;
            log_pc.push_back(result_pc);
        end
        if (timeout_err && first_err < 0) first_err = cyc;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [1:0] w, input logic [3:0] tm,
                        input logic [3:0] wm, input logic [29:0] pc, input logic [3:0] d,
                        output int t_acc);
        bit acc = 0;
        cmd_op = op; cmd_wid = w; cmd_tmask = tm; cmd_wmask = wm; cmd_pc = pc; cmd_delay = d;
        cmd_valid = 1'b1;
        t_acc = -1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = 1;
                t_acc = cyc;
            end
            step();
        end
        cmd_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_accept: command pc=%0h not accepted within 200 cycles", pc);
        end
    endtask

    int t, t2, r, base, n_before;
    logic [29:0] exp_pcs [5];

    initial begin
        reset = 1'b0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_wid = '0; cmd_tmask = '0; cmd_wmask = '0;
        cmd_pc = '0; cmd_delay = '0; stalled_warps = '0;
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", issued_count, 0);

        // TMC, no delay, no stall: pulse three cycles after accept
        send(2'd0, 2'd1, 4'b0101, 4'b0000, 30'h100, 4'd0, t);
        repeat (6) step();
        chk("tmc_time", last_ctl, t + 3);
        chk("tmc_wid", cap_wid, 2'd1);
        chk("tmc_tmask", cap_tm, 4'b0101);
        chk("tmc_pc", cap_pc, 30'h100);
        chk("tmc_count", issued_count, 1);

        // WSPAWN with delay 5
        send(2'd1, 2'd0, 4'b0000, 4'b1110, 30'h80, 4'd5, t);
        repeat (12) step();
        chk("wsp_time", last_wsp, t + 8);
        chk("wsp_wmask", cap_wm, 4'b1110);
        chk("wsp_count", issued_count, 2);

        // JOIN held by a 10-cycle stall on warp 2
        stalled_warps = 4'b0100;
        send(2'd2, 2'd2, 4'b0011, 4'b0000, 30'h200, 4'd0, t);
        repeat (10) step();
        chk("join_held", n_jn, 0);
        stalled_warps = 4'b0000;
        r = cyc;
        repeat (4) step();
        chk("join_time", last_jn, r + 1);
        chk("join_once", n_jn, 1);
        chk("join_wmask0", warp_mask, 4'b0000);

        // Fill the queue behind a stalled holder, including a reserved op
        base = log_pc.size();
        stalled_warps = 4'b0001;
        send(2'd0, 2'd0, 4'b1111, 4'b0000, 30'h20, 4'd0, t);
        send(2'd0, 2'd1, 4'b0001, 4'b0000, 30'h21, 4'd0, t);
        send(2'd2, 2'd3, 4'b0010, 4'b0000, 30'h22, 4'd1, t);
        send(2'd1, 2'd0, 4'b0000, 4'b0110, 30'h23, 4'd0, t);
        send(2'd3, 2'd2, 4'b1111, 4'b1111, 30'h24, 4'd0, t);
        @(negedge clk);
        chk("fifo_full", cmd_ready, 0);
        repeat (5) step();
        chk("fifo_still_full", cmd_ready, 0);
        stalled_warps = 4'b0000;
        send(2'd0, 2'd2, 4'b1000, 4'b0000, 30'h25, 4'd2, t);
        repeat (40) step();
        exp_pcs = '{30'h20, 30'h21, 30'h22, 30'h23, 30'h25};
        chk("order_len", log_pc.size(), base + 5);
        for (int i = 0; i < 5; i++) begin
            if (base + i < log_pc.size()) chk($sformatf("order_%0d", i), log_pc[base + i], exp_pcs[i]);
        end

`ifdef VX_SCHED_DRV_TIMEOUT_EN
        // Warp 0 stalled forever: watchdog fires on the 64th WAIT cycle
        stalled_warps = 4'b0001;
        n_before = n_ctl;
        send(2'd0, 2'd0, 4'b1111, 4'b0000, 30'h300, 4'd0, t);
        repeat (80) step();
        chk("tmo_time", first_err, t + 3 + TMO);
        chk("tmo_nopulse", n_ctl, n_before);
        chk("tmo_flag", timeout_err, 1);
        send(2'd0, 2'd1, 4'b0110, 4'b0000, 30'h301, 4'd0, t2);
        repeat (6) step();
        chk("tmo_next_time", last_ctl, t2 + 3);
        chk("tmo_sticky", timeout_err, 1);
        stalled_warps = 4'b0000;
`else
        // Long stall without watchdog: command waits, then issues
        stalled_warps = 4'b1000;
        n_before = n_ctl;
        send(2'd0, 2'd3, 4'b1111, 4'b0000, 30'h300, 4'd0, t);
        repeat (80) step();
        chk("longwait_held", n_ctl, n_before);
        chk("longwait_busy", busy, 1);
        stalled_warps = 4'b0000;
        r = cyc;
        repeat (3) step();
        chk("longwait_time", last_ctl, r + 1);
        chk("longwait_noerr", timeout_err, 0);
`endif

        // Reset in the middle of a long GAP: command discarded
        send(2'd0, 2'd2, 4'b1010, 4'b0000, 30'h3FF, 4'd8, t);
        repeat (3) step();
        n_before = n_ctl;
        reset = 1'b0;
        #1;
        chk("rstgap_busy", busy, 0);
        chk("rstgap_ready", cmd_ready, 1);
        chk("rstgap_count", issued_count, 0);
        chk("rstgap_pc", result_pc, 0);
        step();
        reset = 1'b1;
        repeat (15) step();
        chk("rstgap_nopulse", n_ctl, n_before);
        chk("rstgap_idle", busy, 0);
        chk("rstgap_ready2", cmd_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vx_sched_wctl_driver.md
VX_SCHED_WCTL_DRIVER -- requirements
Module: VX_sched_wctl_driver

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, warps addressed by wid.
REQ-002 SHALL have parameter NUM_THREADS, default 4, lanes per warp.
REQ-003 SHALL have parameter PC_BITS, default 30, result_pc width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, power of two >= 2, command queue entries.
REQ-005 SHALL have parameter TIMEOUT, default 64, maximum WAIT cycles before error.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 reset  input  1  reset is asynchronous and active-low.
REQ-008 cmd_valid  input  1  command offered.
REQ-009 cmd_ready  output  1  queue not full.
REQ-010 cmd_op  input  2  0=TMC, 1=WSPAWN, 2=JOIN, 3=reserved (dropped).
REQ-011 cmd_wid  input  clog2(NUM_WARPS)  target warp.
REQ-012 cmd_tmask  input  NUM_THREADS  thread mask (TMC/JOIN).
REQ-013 cmd_wmask  input  NUM_WARPS  warp mask (WSPAWN).
REQ-014 cmd_pc  input  PC_BITS  result/spawn PC.
REQ-015 cmd_delay  input  4  idle cycles inserted before issue.
REQ-016 stalled_warps  input  NUM_WARPS  per-warp stall from scheduler.
REQ-017 warp_ctl_valid, wspawn_valid, join_valid  output  1 each  one-cycle event pulses.
REQ-018 wid  output  clog2(NUM_WARPS); thread_mask  output  NUM_THREADS; warp_mask  output  NUM_WARPS; result_pc  output  PC_BITS -- event payload, registered.
REQ-019 issued_count  output  16  saturating count of issued events.
REQ-020 timeout_err  output  1  sticky watchdog flag.
REQ-021 busy  output  1  state != IDLE or queue non-empty.

Function
REQ-022 Command SHALL be accepted on cycle where cmd_valid && cmd_ready; cmd_ready SHALL equal !full, independent of cmd_valid.
REQ-023 Queue SHALL be FIFO order, no bypass; push when full SHALL be impossible (ready low); simultaneous push and pop SHALL keep occupancy.
REQ-024 FSM states: IDLE, GAP, WAIT, ISSUE.
REQ-025 IDLE: if queue non-empty, pop head, latch fields, load gap counter = cmd_delay, go GAP; op 3 SHALL be popped and discarded, staying IDLE.
REQ-026 GAP: counter non-zero -> decrement; counter zero -> ISSUE if target free, else WAIT.
REQ-027 Target free: TMC/JOIN when stalled_warps[wid]==0; WSPAWN when (stalled_warps & warp_mask)==0.
REQ-028 WAIT: go ISSUE on first cycle target is free; increment wait counter each cycle otherwise.
REQ-029 ISSUE: exactly one of warp_ctl_valid/wspawn_valid/join_valid high for one cycle per op, payload valid same cycle; next state IDLE.
REQ-030 Latency: accept at cycle T, delay d, no stall -> pulse at T+3+d.
REQ-031 Payload outputs SHALL hold last issued values between pulses; warp_mask SHALL be 0 for non-WSPAWN issues.
REQ-032 issued_count SHALL increment on each pulse, saturating at 16'hFFFF.

Reset
REQ-033 reset low SHALL immediately clear queue, FSM to IDLE, all counters, all outputs to 0, timeout_err to 0; cmd_ready SHALL be 1 after deassertion.
REQ-034 Reset mid-WAIT or mid-GAP SHALL discard the in-flight command without a pulse.

Configuration
REQ-035 Macro VX_SCHED_DRV_TIMEOUT_EN defined: when wait counter reaches TIMEOUT, timeout_err SHALL set (sticky until reset) and the command SHALL be dropped without pulse, FSM to IDLE.
REQ-036 Macro undefined: no wait counter; WAIT SHALL persist until target free; timeout_err tied 0.

Verification
REQ-037 TMC wid=1 tmask=4'b0101 pc=0x100 delay=0, no stalls -> warp_ctl_valid at T+3, wid=1, thread_mask=0101, result_pc=0x100, issued_count=1.
REQ-038 Push 5 commands back-to-back, FIFO_DEPTH=4, no pops yet -> cmd_ready low after 4th accept; 5th held; all issued in order.
REQ-039 JOIN wid=2 with stalled_warps[2]=1 for 10 cycles -> join_valid exactly one cycle after stall clears.
REQ-040 WSPAWN wmask=4'b1110 pc=0x80 delay=5 -> wspawn_valid at T+8, warp_mask=1110.
REQ-041 VX_SCHED_DRV_TIMEOUT_EN, TIMEOUT=64, wid=0 stalled forever -> timeout_err at 64th WAIT cycle, no pulse, next command proceeds.
REQ-042 reset low during GAP delay=8 -> no pulse, outputs 0, busy=0, cmd_ready=1.
